call_request_ctrl: RTL and testbench

//  Upstream stage of the elevator floor FSM. Captures the hall/car call buttons and latches them as

---
 rtl/elevador_pkg.sv | 18 +
 rtl/call_request_ctrl_if.sv | 23 ++
 rtl/btn_edge_sync.sv | 28 ++
 rtl/call_request_ctrl.sv | 95 +++++++++
 tb/tb_call_request_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevador_pkg.sv
// Shared elevator definitions: floor codes, door state encoding and default timings.
package elevador_pkg;

    localparam int unsigned FLOOR_W          = 2;
    localparam int unsigned N_FLOORS_DEF     = 3;
    localparam int unsigned DOOR_OPEN_S_DEF  = 3;

    localparam logic [FLOOR_W-1:0] FLOOR_0       = 2'b00;
    localparam logic [FLOOR_W-1:0] FLOOR_1       = 2'b01;
    localparam logic [FLOOR_W-1:0] FLOOR_2       = 2'b10;
    localparam logic [FLOOR_W-1:0] FLOOR_INVALID = 2'b11;

    typedef enum logic {
        DOOR_CLOSED = 1'b0,
        DOOR_OPEN   = 1'b1
    } door_state_e;

endpackage

// File: rtl/call_request_ctrl_if.sv
// Bundle between the call-request stage and its environment (buttons, floor FSM, door actuator).
interface call_request_ctrl_if #(
    parameter int unsigned N_FLOORS = 3
) ();

    logic                              tick;
    logic [N_FLOORS-1:0]               btn_n;
    logic [elevador_pkg::FLOOR_W-1:0]  floor;
    logic                              moving;
    logic [N_FLOORS-1:0]               req;
    logic                              door;

    modport master (
        output tick, btn_n, floor, moving,
        input  req, door
    );

    modport slave (
        input  tick, btn_n, floor, moving,
        output req, door
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an active-low button plus falling-edge detect -> one-cycle press pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_c_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Released level (1) after reset so a held button yields a press once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= btn_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign press_c_o = prev_q & ~sync_q;

endmodule

// File: rtl/call_request_ctrl.sv
// Latches floor call requests and runs the door: opens at a requested floor when the car is idle,
// holds it for DOOR_OPEN_S ticks (reloaded by a press at that floor), then closes.
module call_request_ctrl
    import elevador_pkg::*;
#(
    parameter int unsigned N_FLOORS    = N_FLOORS_DEF,
    parameter int unsigned DOOR_OPEN_S = DOOR_OPEN_S_DEF
) (
    input  logic               clk,
    input  logic               reset,
    call_request_ctrl_if.slave ctrl_if
);

    localparam int unsigned TIMER_W = $clog2(DOOR_OPEN_S + 1);

    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] floor_sel;
    logic [N_FLOORS-1:0] req_q;
    logic [N_FLOORS-1:0] req_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    door_state_e         state_q;
    door_state_e         state_d;
    logic                req_hit;
    logic                press_hit;

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_btn
        btn_edge_sync u_sync (
            .clk       (clk),
            .reset     (reset),
            .btn_n_i   (ctrl_if.btn_n[i]),
            .press_c_o (press[i])
        );
    end

    // One-hot of the current floor; all zero for the invalid code.
    always_comb begin
        floor_sel = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            floor_sel[i] = (ctrl_if.floor == FLOOR_W'(i)) && (ctrl_if.floor != FLOOR_INVALID);
        end
    end

    assign req_hit   = |(req_q & floor_sel);
    assign press_hit = |(press & floor_sel);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        req_d   = req_q | press;
        case (state_q)
            DOOR_CLOSED: begin
                if (!ctrl_if.moving && req_hit) begin
                    state_d = DOOR_OPEN;
                    timer_d = TIMER_W'(DOOR_OPEN_S);
                    req_d   = (req_q | press) & ~floor_sel;
                end
            end
            DOOR_OPEN: begin
                // A press at the open floor keeps the door open instead of queueing a call.
                if (press_hit) begin
                    timer_d = TIMER_W'(DOOR_OPEN_S);
                    req_d   = req_q | (press & ~floor_sel);
                end else if (ctrl_if.tick) begin
                    if (timer_q == TIMER_W'(1)) begin
                        state_d = DOOR_CLOSED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            default: begin
                state_d = DOOR_CLOSED;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DOOR_CLOSED;
            timer_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    assign ctrl_if.req  = req_q;
    assign ctrl_if.door = state_q;

endmodule

// File: tb/tb_call_request_ctrl.sv
// Directed and randomized bench for call_request_ctrl against a cycle-level behavioural model.
module tb_call_request_ctrl;
    import elevador_pkg::*;

    localparam int unsigned NF  = 3;
    localparam int unsigned DOS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    call_request_ctrl_if #(.N_FLOORS(NF)) bus ();

    call_request_ctrl #(.N_FLOORS(NF), .DOOR_OPEN_S(DOS)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: a button level seen low at edge e-2 after high at e-3 counts as a press at edge e.
    logic [NF-1:0] m_req, h1, h2, h3;
    logic          m_door;
    int            m_rem;

    always @(posedge clk) begin : model
        logic [NF-1:0] p;
        logic [NF-1:0] nreq;
        logic          nd;
        int            nr;
        int            f;
        logic          fv;
        if (reset) begin
            m_req  <= '0;
            m_door <= 1'b0;
            m_rem  <= 0;
            h1     <= '1;
            h2     <= '1;
            h3     <= '1;
        end else begin
            p    = h3 & ~h2;
            f    = int'(bus.floor);
            fv   = (f < int'(NF));
            nreq = m_req;
            nd   = m_door;
            nr   = m_rem;
            if (m_door) begin
                if (fv && p[f]) begin
                    nr   = DOS;
                    p[f] = 1'b0;
                end else if (bus.tick) begin
                    nr = nr - 1;
                    if (nr == 0) nd = 1'b0;
                end
            end else if (!bus.moving && fv && m_req[f]) begin
                nd      = 1'b1;
                nr      = DOS;
                nreq[f] = 1'b0;
                p[f]    = 1'b0;
            end
            nreq = nreq | p;
            m_req  <= nreq;
            m_door <= nd;
            m_rem  <= nr;
            h3 <= h2;
            h2 <= h1;
            h1 <= bus.btn_n;
        end
    end

    task automatic test_reset();
        reset = 1'b1; bus.tick = 1'b0; bus.btn_n = '1; bus.floor = FLOOR_0; bus.moving = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.req !== 3'b000 || bus.door !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b door=%b expected req=000 door=0", bus.req, bus.door);
        end
        for (int i = 0; i < 20; i++) begin
            bus.tick = (i % 4 == 1);
            @(negedge clk);
            checks++;
            if (bus.req !== 3'b000 || bus.door !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: req=%b door=%b expected req=000 door=0", i, bus.req, bus.door);
            end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_press_latency();
        bus.floor = FLOOR_0; bus.moving = 1'b0;
        bus.btn_n = 3'b011;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.btn_n = 3'b111;
            checks++;
            if (bus.req !== ((k >= 3) ? 3'b100 : 3'b000) || bus.door !== 1'b0) begin
                errors++;
                $display("FAIL latency edge %0d: req=%b door=%b expected req=%b door=0",
                         k, bus.req, bus.door, (k >= 3) ? 3'b100 : 3'b000);
            end
        end
    endtask

    task automatic test_door_open();
        bus.floor = FLOOR_1; bus.moving = 1'b0;
        bus.btn_n = 3'b101;
        @(negedge clk); bus.btn_n = 3'b111;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.req !== 3'b110 || bus.door !== 1'b0) begin
            errors++;
            $display("FAIL open_latch: req=%b door=%b expected req=110 door=0", bus.req, bus.door);
        end
        @(negedge clk);
        checks++;
        if (bus.req !== 3'b100 || bus.door !== 1'b1) begin
            errors++;
            $display("FAIL open_edge: req=%b door=%b expected req=100 door=1", bus.req, bus.door);
        end
        for (int t = 1; t <= 3; t++) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            checks++;
            if (bus.door !== (t < 3)) begin
                errors++;
                $display("FAIL open_tick%0d: door=%b expected %b", t, bus.door, (t < 3));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reload();
        bus.floor = FLOOR_1; bus.moving = 1'b0;
        bus.btn_n = 3'b101;
        @(negedge clk); bus.btn_n = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.door !== 1'b1 || bus.req !== 3'b100) begin
            errors++;
            $display("FAIL reload_open: req=%b door=%b expected req=100 door=1", bus.req, bus.door);
        end
        repeat (2) begin
            bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0; @(negedge clk);
        end
        bus.btn_n = 3'b101;
        @(negedge clk); bus.btn_n = 3'b111;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.door !== 1'b1 || bus.req !== 3'b100) begin
            errors++;
            $display("FAIL reload_press: req=%b door=%b expected req=100 door=1", bus.req, bus.door);
        end
        for (int t = 1; t <= 3; t++) begin
            bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
            checks++;
            if (bus.door !== (t < 3) || bus.req !== 3'b100) begin
                errors++;
                $display("FAIL reload_tick%0d: req=%b door=%b expected req=100 door=%b",
                         t, bus.req, bus.door, (t < 3));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_moving();
        bus.floor = FLOOR_1; bus.moving = 1'b1;
        bus.btn_n = 3'b101;
        @(negedge clk); bus.btn_n = 3'b111;
        for (int k = 0; k < 6; k++) begin
            bus.tick = (k == 3);
            @(negedge clk);
        end
        bus.tick = 1'b0;
        checks++;
        if (bus.req !== 3'b110 || bus.door !== 1'b0) begin
            errors++;
            $display("FAIL moving_hold: req=%b door=%b expected req=110 door=0", bus.req, bus.door);
        end
        bus.moving = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req !== 3'b100 || bus.door !== 1'b1) begin
            errors++;
            $display("FAIL moving_fall: req=%b door=%b expected req=100 door=1", bus.req, bus.door);
        end
        repeat (3) begin
            bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0; @(negedge clk);
        end
        bus.floor = FLOOR_INVALID;
        bus.btn_n = 3'b100;
        @(negedge clk); bus.btn_n = 3'b111;
        for (int k = 0; k < 6; k++) begin
            bus.tick = (k % 2 == 0);
            @(negedge clk);
            checks++;
            if (bus.door !== 1'b0) begin
                errors++;
                $display("FAIL invalid_floor_door[%0d]: door=%b expected 0", k, bus.door);
            end
        end
        bus.tick = 1'b0;
        checks++;
        if (bus.req !== 3'b111) begin
            errors++;
            $display("FAIL invalid_floor_req: req=%b expected 111", bus.req);
        end
    endtask

    task automatic test_reset_mid();
        bus.floor = FLOOR_1; bus.moving = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req !== 3'b101 || bus.door !== 1'b1) begin
            errors++;
            $display("FAIL mid_open: req=%b door=%b expected req=101 door=1", bus.req, bus.door);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.req !== 3'b000 || bus.door !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: req=%b door=%b expected req=000 door=0", bus.req, bus.door);
        end
        bus.btn_n = 3'b101;
        @(negedge clk); bus.btn_n = 3'b111;
        repeat (3) @(negedge clk);
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0; @(negedge clk);
        // Press reaches the FSM on the third edge after btn goes low; a tick lands on that edge too.
        bus.btn_n = 3'b101;
        @(negedge clk); bus.btn_n = 3'b111;
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0;
        checks++;
        if (bus.door !== 1'b1 || bus.req !== 3'b000) begin
            errors++;
            $display("FAIL tick_press: req=%b door=%b expected req=000 door=1", bus.req, bus.door);
        end
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
            checks++;
            if (bus.door !== (t < 3)) begin
                errors++;
                $display("FAIL tick_press_tick%0d: door=%b expected %b", t, bus.door, (t < 3));
            end
        end
    endtask

    task automatic test_random();
        logic [NF-1:0] b;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < int'(NF); i++) b[i] = ($urandom_range(0, 5) != 0);
            bus.btn_n  = b;
            bus.tick   = ($urandom_range(0, 5) == 0);
            bus.moving = ($urandom_range(0, 3) == 0);
            if (!m_door && $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.floor = FLOOR_0;
                    1:       bus.floor = FLOOR_1;
                    2:       bus.floor = FLOOR_2;
                    default: bus.floor = FLOOR_INVALID;
                endcase
            end
            @(negedge clk);
            checks++;
            if (bus.req !== m_req || bus.door !== m_door) begin
                errors++;
                $display("FAIL random[%0d]: req=%b door=%b expected req=%b door=%b",
                         n, bus.req, bus.door, m_req, m_door);
            end
        end
        bus.btn_n = '1; bus.tick = 1'b0; bus.moving = 1'b0;
    endtask

    initial begin
        bus.tick = 1'b0; bus.btn_n = '1; bus.floor = FLOOR_0; bus.moving = 1'b0;
        test_reset();
        test_press_latency();
        test_door_open();
        test_reload();
        test_moving();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
